uart_io: RTL

//  IO responder for the CPU's byte IO port: other end of the io_in/io_out vld/rdy handshakes.

---
 rtl/uart_io.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_io.sv
// UART responder for the CPU byte IO port.
// RX/TX FIFOs sit between the vld/rdy handshakes and the serial line.
module uart_io #(
    parameter int CLK_PER_BIT = 868,
    parameter int FIFO_LOG    = 4
) (
    input  logic       clk,
    input  logic       rstn,
    output logic [7:0] io_in_data,
    output logic       io_in_vld,
    input  logic       io_in_rdy,
    input  logic [7:0] io_out_data,
    input  logic       io_out_vld,
    output logic       io_out_rdy,
    output logic [4:0] io_err,
    input  logic       uart_rxd,
    output logic       uart_txd
);

    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int CW = $clog2(CLK_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2);
    localparam logic [FIFO_LOG:0] FULL = (FIFO_LOG + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BRK   = 3'd4;

    logic [7:0]          rxf_mem [DEPTH];
    logic [FIFO_LOG-1:0] rxf_wp_q, rxf_rp_q;
    logic [FIFO_LOG:0]   rxf_cnt_q, rxf_cnt_d;
    logic                rx_push, rx_pop, rx_wr, rx_full;

    logic [7:0]          txf_mem [DEPTH];
    logic [FIFO_LOG-1:0] txf_wp_q, txf_rp_q;
    logic [FIFO_LOG:0]   txf_cnt_q, txf_cnt_d;
    logic                tx_push, tx_pop, tx_nempty;

    logic          rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]    rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [2:0]    err_q, err_set;

    logic [2:0]    tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          txd_q, txd_d;

    assign io_in_vld  = rxf_cnt_q != '0;
    assign io_in_data = io_in_vld ? rxf_mem[rxf_rp_q] : 8'h00;
    assign io_out_rdy = txf_cnt_q != FULL;
    assign io_err     = {2'b00, err_q};
    assign uart_txd   = txd_q;

    assign rx_pop  = io_in_vld & io_in_rdy;
    assign rx_full = rxf_cnt_q == FULL;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign rx_wr   = rx_push & (~rx_full | rx_pop);

    assign tx_push   = io_out_vld & io_out_rdy;
    assign tx_nempty = txf_cnt_q != '0;

    always_comb begin
        rxf_cnt_d = rxf_cnt_q;
        if (rx_wr & ~rx_pop)
            rxf_cnt_d = rxf_cnt_q + 1'b1;
        else if (~rx_wr & rx_pop)
            rxf_cnt_d = rxf_cnt_q - 1'b1;
        txf_cnt_d = txf_cnt_q;
        if (tx_push & ~tx_pop)
            txf_cnt_d = txf_cnt_q + 1'b1;
        else if (~tx_push & tx_pop)
            txf_cnt_d = txf_cnt_q - 1'b1;
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + 1'b1;
        rx_idx_d = rx_idx_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        err_set  = 3'b000;
        unique case (rx_st_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q & ~rx_s2_q)
                    rx_st_d = S_START;
            end
            S_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    if (!rx_s2_q) begin
                        rx_st_d = S_DATA;
                    end else begin
                        rx_st_d = S_IDLE;
                        err_set[2] = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_idx_d = rx_idx_q + 1'b1;
                    if (rx_idx_q == 3'd7)
                        rx_st_d = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_push = 1'b1;
                        rx_st_d = S_IDLE;
                    end else begin
                        err_set[0] = 1'b1;
                        rx_st_d = S_BRK;
                    end
                end
            end
            S_BRK: begin
                rx_cnt_d = '0;
                if (rx_s2_q)
                    rx_st_d = S_IDLE;
            end
            default: begin
                rx_cnt_d = '0;
                rx_st_d  = S_IDLE;
            end
        endcase
        err_set[1] = rx_push & rx_full & ~rx_pop;
    end

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + 1'b1;
        tx_idx_d = tx_idx_q;
        tx_sh_d  = tx_sh_q;
        tx_pop   = 1'b0;
        unique case (tx_st_q)
            S_IDLE: begin
                tx_cnt_d = '0;
                if (tx_nempty) begin
                    tx_pop  = 1'b1;
                    tx_sh_d = txf_mem[txf_rp_q];
                    tx_st_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    tx_idx_d = '0;
                    tx_st_d  = S_DATA;
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_idx_d = tx_idx_q + 1'b1;
                    if (tx_idx_q == 3'd7)
                        tx_st_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d = '0;
                    // Chain straight into the next start bit to avoid idle gaps.
                    if (tx_nempty) begin
                        tx_pop  = 1'b1;
                        tx_sh_d = txf_mem[txf_rp_q];
                        tx_st_d = S_START;
                    end else begin
                        tx_st_d = S_IDLE;
                    end
                end
            end
            default: begin
                tx_cnt_d = '0;
                tx_st_d  = S_IDLE;
            end
        endcase
        unique case (tx_st_q)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = tx_sh_q[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_wr)
            rxf_mem[rxf_wp_q] <= rx_sh_q;
        if (tx_push)
            txf_mem[txf_wp_q] <= io_out_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxf_wp_q  <= '0;
            rxf_rp_q  <= '0;
            rxf_cnt_q <= '0;
            txf_wp_q  <= '0;
            txf_rp_q  <= '0;
            txf_cnt_q <= '0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= S_IDLE;
            rx_cnt_q  <= '0;
            rx_idx_q  <= '0;
            rx_sh_q   <= '0;
            err_q     <= '0;
            tx_st_q   <= S_IDLE;
            tx_cnt_q  <= '0;
            tx_idx_q  <= '0;
            tx_sh_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            if (rx_wr)
                rxf_wp_q <= rxf_wp_q + 1'b1;
            if (rx_pop)
                rxf_rp_q <= rxf_rp_q + 1'b1;
            rxf_cnt_q <= rxf_cnt_d;
            if (tx_push)
                txf_wp_q <= txf_wp_q + 1'b1;
            if (tx_pop)
                txf_rp_q <= txf_rp_q + 1'b1;
            txf_cnt_q <= txf_cnt_d;
            rx_s1_q   <= uart_rxd;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_idx_q  <= rx_idx_d;
            rx_sh_q   <= rx_sh_d;
            err_q     <= err_q | err_set;
            tx_st_q   <= tx_st_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_idx_q  <= tx_idx_d;
            tx_sh_q   <= tx_sh_d;
            txd_q     <= txd_d;
        end
    end

endmodule
